irq_trap_ctrl: RTL and testbench

// Sequences machine-mode interrupt entry/exit for the CPU around the CSR register file.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_trap_ctrl.sv | 113 +++++++++++
 tb/tb_irq_trap_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt sequencer.
package irq_pkg;

  // Sequencer states; exported on the debug port so checkers can bind to them.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_TAKE    = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RET     = 3'd4,
    ST_SLEEP   = 3'd5
  } irq_state_t;

  // mip/mie bit positions; the mcause code equals the bit index.
  localparam int MIP_MEI_BIT = 11;
  localparam int MIP_MTI_BIT = 7;

  localparam logic [3:0] CAUSE_MEI  = 4'(MIP_MEI_BIT);
  localparam logic [3:0] CAUSE_MTI  = 4'(MIP_MTI_BIT);
  localparam logic [3:0] CAUSE_NONE = 4'd0;

endpackage

// File: rtl/irq_prio_enc.sv
// Picks the cause code among simultaneously pending interrupts.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter bit EXT_FIRST = 1'b1
) (
  input  logic       pending_e,
  input  logic       pending_t,
  output logic [3:0] cause
);

  // Fixed-priority select; EXT_FIRST chooses which source wins a tie.
  always_comb begin
    cause = CAUSE_NONE;
    if (EXT_FIRST) begin
      if (pending_e)      cause = CAUSE_MEI;
      else if (pending_t) cause = CAUSE_MTI;
    end else begin
      if (pending_t)      cause = CAUSE_MTI;
      else if (pending_e) cause = CAUSE_MEI;
    end
  end

endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt entry/exit sequencer: gates MEI/MTI requests,
// waits for a safe pipeline boundary, and sequences trap entry, MRET and WFI.
//
// Handshake note: there is no valid/ready pair here. Requests are levels,
// sampled every cycle; interrupt_taken, MRET and redirect are single-cycle
// strobes that the CSR file and fetch unit must accept unconditionally.
module irq_trap_ctrl
  import irq_pkg::*;
#(
  parameter int DRAIN_MAX = 8,
  parameter bit EXT_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SENSOR_CTRL_interrupt,
  input  logic       WDT_interrupt,
  input  logic       MSTATUS_MIE,
  input  logic       MEIE,
  input  logic       MTIE,
  input  logic       wfi_insn,
  input  logic       mret_insn,
  input  logic       pipe_stall,
  output logic       interrupt_taken,
  output logic       MRET,
  output logic       WFI_mode,
  output logic       redirect,
  output logic       redirect_sel,
  output logic [3:0] irq_cause,
  output logic       in_handler,
  output irq_state_t dbg_state
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);

  irq_state_t state, next_state;
  logic [3:0] drain_cnt;
  logic       pending_e, pending_t, pending_any, take_ok;
  logic [3:0] cause_sel;

  assign pending_e   = SENSOR_CTRL_interrupt & MEIE;
  assign pending_t   = WDT_interrupt & MTIE;
  assign pending_any = pending_e | pending_t;
  assign take_ok     = MSTATUS_MIE & pending_any & ~in_handler;
  assign dbg_state   = state;

  irq_prio_enc #(
    .EXT_FIRST (EXT_FIRST)
  ) u_prio (
    .pending_e (pending_e),
    .pending_t (pending_t),
    .cause     (cause_sel)
  );

  // Next-state decode; interrupt entry outranks WFI and MRET outside a handler.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (take_ok)       next_state = ST_DRAIN;
        else if (wfi_insn) next_state = ST_SLEEP;
      end
      ST_DRAIN: begin
        // A request that goes away while draining is dropped silently.
        if (!pending_any)                               next_state = ST_RUN;
        else if (!pipe_stall || drain_cnt == DRAIN_LAST) next_state = ST_TAKE;
      end
      ST_TAKE:    next_state = ST_HANDLER;
      ST_HANDLER: if (mret_insn && !pipe_stall) next_state = ST_RET;
      ST_RET:     next_state = ST_RUN;
      ST_SLEEP: begin
        // Wake ignores MIE; MIE only decides between trapping and resuming.
        if (pending_any) next_state = MSTATUS_MIE ? ST_DRAIN : ST_RUN;
      end
      default:    next_state = ST_RUN;
    endcase
  end

  // State, drain counter and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_RUN;
      drain_cnt       <= 4'd0;
      interrupt_taken <= 1'b0;
      MRET            <= 1'b0;
      WFI_mode        <= 1'b0;
      redirect        <= 1'b0;
      redirect_sel    <= 1'b0;
      irq_cause       <= CAUSE_NONE;
      in_handler      <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state == ST_DRAIN && state != ST_DRAIN)
        drain_cnt <= 4'd0;
      else if (state == ST_DRAIN && drain_cnt != 4'hF)
        drain_cnt <= drain_cnt + 4'd1;

      interrupt_taken <= (next_state == ST_TAKE);
      MRET            <= (next_state == ST_RET);
      redirect        <= (next_state == ST_TAKE) || (next_state == ST_RET);
      redirect_sel    <= (next_state == ST_RET);
      WFI_mode        <= (next_state == ST_SLEEP);
      in_handler      <= (next_state == ST_HANDLER);

      // Cause is captured on entry and held until the return strobe.
      if (next_state == ST_TAKE)
        irq_cause <= cause_sel;
      else if (next_state == ST_RET)
        irq_cause <= CAUSE_NONE;
    end
  end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: entry latency, priority, forced drain,
// WFI wake, handler masking, MRET return and mid-drain reset.
module tb_irq_trap_ctrl;
  import irq_pkg::*;

  logic       clk;
  logic       rst;
  logic       sensor_irq, wdt_irq, mie, meie, mtie;
  logic       wfi_insn, mret_insn, pipe_stall;

  logic       interrupt_taken, mret_out, wfi_mode, redirect, redirect_sel, in_handler;
  logic [3:0] irq_cause;
  irq_state_t dbg_state;

  // Second instance with MTI-first priority, sharing all inputs.
  logic       x_taken, x_mret, x_wfi, x_redirect, x_sel, x_in_handler;
  logic [3:0] x_cause;
  irq_state_t x_state;

  int checks   = 0;
  int failures = 0;

  irq_trap_ctrl #(.DRAIN_MAX(8), .EXT_FIRST(1'b1)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .SENSOR_CTRL_interrupt (sensor_irq),
    .WDT_interrupt         (wdt_irq),
    .MSTATUS_MIE           (mie),
    .MEIE                  (meie),
    .MTIE                  (mtie),
    .wfi_insn              (wfi_insn),
    .mret_insn             (mret_insn),
    .pipe_stall            (pipe_stall),
    .interrupt_taken       (interrupt_taken),
    .MRET                  (mret_out),
    .WFI_mode              (wfi_mode),
    .redirect              (redirect),
    .redirect_sel          (redirect_sel),
    .irq_cause             (irq_cause),
    .in_handler            (in_handler),
    .dbg_state             (dbg_state)
  );

  irq_trap_ctrl #(.DRAIN_MAX(8), .EXT_FIRST(1'b0)) dut_mti (
    .clk                   (clk),
    .rst                   (rst),
    .SENSOR_CTRL_interrupt (sensor_irq),
    .WDT_interrupt         (wdt_irq),
    .MSTATUS_MIE           (mie),
    .MEIE                  (meie),
    .MTIE                  (mtie),
    .wfi_insn              (wfi_insn),
    .mret_insn             (mret_insn),
    .pipe_stall            (pipe_stall),
    .interrupt_taken       (x_taken),
    .MRET                  (x_mret),
    .WFI_mode              (x_wfi),
    .redirect              (x_redirect),
    .redirect_sel          (x_sel),
    .irq_cause             (x_cause),
    .in_handler            (x_in_handler),
    .dbg_state             (x_state)
  );

  // Clock and run-time bound.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  // Advance one cycle and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".taken"},   32'(interrupt_taken), 32'd0);
    check({tag, ".mret"},    32'(mret_out),        32'd0);
    check({tag, ".wfi"},     32'(wfi_mode),        32'd0);
    check({tag, ".redir"},   32'(redirect),        32'd0);
    check({tag, ".sel"},     32'(redirect_sel),    32'd0);
    check({tag, ".cause"},   32'(irq_cause),       32'd0);
    check({tag, ".handler"}, 32'(in_handler),      32'd0);
    check({tag, ".state"},   32'(dbg_state),       32'(ST_RUN));
  endtask

  initial begin
    rst = 1'b0;
    sensor_irq = 0; wdt_irq = 0; mie = 0; meie = 0; mtie = 0;
    wfi_insn = 0; mret_insn = 0; pipe_stall = 0;

    // Reset state.
    tick();
    tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // MRET in RUN without a handler is ignored.
    mret_insn = 1;
    tick();
    mret_insn = 0;
    check("mret_in_run.mret",  32'(mret_out),  32'd0);
    check("mret_in_run.redir", 32'(redirect),  32'd0);
    check("mret_in_run.state", 32'(dbg_state), 32'(ST_RUN));

    // MEI with no stall: taken two cycles after the request.
    sensor_irq = 1; meie = 1; mie = 1;
    tick();
    check("mei.c1.taken", 32'(interrupt_taken), 32'd0);
    check("mei.c1.state", 32'(dbg_state),       32'(ST_DRAIN));
    tick();
    check("mei.c2.taken", 32'(interrupt_taken), 32'd1);
    check("mei.c2.redir", 32'(redirect),        32'd1);
    check("mei.c2.sel",   32'(redirect_sel),    32'd0);
    check("mei.c2.cause", 32'(irq_cause),       32'd11);
    tick();
    check("mei.hdl.taken",   32'(interrupt_taken), 32'd0);
    check("mei.hdl.redir",   32'(redirect),        32'd0);
    check("mei.hdl.handler", 32'(in_handler),      32'd1);
    check("mei.hdl.cause",   32'(irq_cause),       32'd11);

    // New MEI stays asserted inside the handler: no further entry.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hdl_mask.taken", 32'(interrupt_taken), 32'd0);
      check("hdl_mask.state", 32'(dbg_state),       32'(ST_HANDLER));
    end

    // MRET held off by a stall, then accepted.
    mret_insn = 1; pipe_stall = 1;
    tick();
    check("mret_stall.mret",  32'(mret_out),  32'd0);
    check("mret_stall.state", 32'(dbg_state), 32'(ST_HANDLER));
    pipe_stall = 0;
    tick();
    mret_insn = 0; sensor_irq = 0;
    check("mret.mret",    32'(mret_out),     32'd1);
    check("mret.redir",   32'(redirect),     32'd1);
    check("mret.sel",     32'(redirect_sel), 32'd1);
    check("mret.cause",   32'(irq_cause),    32'd0);
    check("mret.handler", 32'(in_handler),   32'd0);
    tick();
    check_idle("after_mret");

    // Simultaneous MEI+MTI with a WFI in the same cycle: interrupt wins.
    sensor_irq = 1; wdt_irq = 1; mtie = 1; wfi_insn = 1;
    tick();
    wfi_insn = 0;
    check("both.c1.state", 32'(dbg_state), 32'(ST_DRAIN));
    check("both.c1.wfi",   32'(wfi_mode),  32'd0);
    tick();
    check("both.taken",     32'(interrupt_taken), 32'd1);
    check("both.cause_ext", 32'(irq_cause),       32'd11);
    check("both.cause_mti", 32'(x_cause),         32'd7);
    sensor_irq = 0; wdt_irq = 0;
    tick();
    mret_insn = 1;
    tick();
    mret_insn = 0;
    check("both.mret", 32'(mret_out), 32'd1);
    tick();
    check_idle("after_both");

    // Stall held long: entry forced exactly 9 cycles after the request.
    pipe_stall = 1; sensor_irq = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("drain.wait.taken", 32'(interrupt_taken), 32'd0);
    end
    tick();
    check("drain.forced.taken", 32'(interrupt_taken), 32'd1);
    check("drain.forced.state", 32'(dbg_state),       32'(ST_TAKE));
    sensor_irq = 0;
    tick();
    mret_insn = 1; pipe_stall = 0;
    tick();
    mret_insn = 0;
    check("drain.mret", 32'(mret_out), 32'd1);
    tick();
    check_idle("after_drain");

    // WFI with MIE=0: MTI wakes the core without a trap.
    mie = 0; wfi_insn = 1;
    tick();
    wfi_insn = 0;
    check("wfi.enter.wfi",   32'(wfi_mode),  32'd1);
    check("wfi.enter.state", 32'(dbg_state), 32'(ST_SLEEP));
    tick();
    check("wfi.hold.wfi", 32'(wfi_mode), 32'd1);
    wdt_irq = 1;
    tick();
    check("wfi.wake.wfi",   32'(wfi_mode),        32'd0);
    check("wfi.wake.state", 32'(dbg_state),       32'(ST_RUN));
    check("wfi.wake.taken", 32'(interrupt_taken), 32'd0);
    tick();
    check("wfi.after.taken", 32'(interrupt_taken), 32'd0);
    wdt_irq = 0;
    tick();

    // Reset asserted during DRAIN.
    mie = 1; sensor_irq = 1; pipe_stall = 1;
    tick();
    check("rst_drain.state", 32'(dbg_state), 32'(ST_DRAIN));
    rst = 0;
    tick();
    check_idle("rst_drain");
    rst = 1; sensor_irq = 0; pipe_stall = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_release.taken", 32'(interrupt_taken), 32'd0);
      check("rst_release.state", 32'(dbg_state),       32'(ST_RUN));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
